// File: rtl/if_predict.sv
// Fetch PC generator with static BTFN prediction and the IF/ID pipeline register.
// Optional return-address stack enabled by defining IF_PREDICT_RAS_EN.
module if_predict #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic        inst_jal_i,
   input  logic        inst_jalr_i,
   input  logic        inst_bxx_i,
   input  logic [31:0] jump_and_branch_imm_i,
   input  logic        hold_flag_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_addr_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc;
   logic [31:0] inst_q;
   logic [31:0] addr_q;
   logic        taken_q;
   logic [31:0] paddr_q;

   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic        static_taken;
   logic        taken;
   logic [31:0] target;
   logic [31:0] next_pc;
   logic        normal;

   assign pc_o         = pc;
   assign inst_o       = inst_q;
   assign inst_addr_o  = addr_q;
   assign pred_taken_o = taken_q;
   assign pred_addr_o  = paddr_q;

   // Both adders wrap naturally modulo 2^32; alignment faults are left to execute.
   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc + jump_and_branch_imm_i;
   assign static_taken  = inst_jal_i | (inst_bxx_i & jump_and_branch_imm_i[31]);
   assign normal        = !jump_flag_i && !hold_flag_i;

`ifdef IF_PREDICT_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [31:0]   ras_mem [RAS_DEPTH];
   logic [PW-1:0] ras_ptr;
   logic [PW:0]   ras_cnt;
   logic [4:0]    rd;
   logic [4:0]    rs1;
   logic          rd_link;
   logic          rs1_link;
   logic          ras_push;
   logic          ras_pop;
   logic          ras_hit;
   logic          ras_en;
   logic          ras_wr_en;
   logic [PW-1:0] ras_wr_idx;
   logic [31:0]   ras_top;

   assign rd       = inst_i[11:7];
   assign rs1      = inst_i[19:15];
   assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
   assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
   assign ras_push = (inst_jal_i | inst_jalr_i) & rd_link;
   assign ras_pop  = inst_jalr_i & rs1_link & !(rd_link && (rd == rs1));
   assign ras_hit  = ras_pop && (ras_cnt != '0);
   assign ras_top  = ras_mem[ras_ptr];
   assign ras_en   = !rst && normal;

   assign taken  = static_taken | ras_hit;
   assign target = ras_hit ? ras_top : branch_target;

   // ras_ptr always addresses the current top; a push first advances it.
   always_comb begin
      ras_wr_en  = 1'b0;
      ras_wr_idx = ras_ptr;
      if (ras_en && ras_push) begin
         ras_wr_en = 1'b1;
         if (!ras_hit)
            ras_wr_idx = ras_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ras_wr_en)
         ras_mem[ras_wr_idx] <= pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (ras_en) begin
         if (ras_hit && ras_push) begin
            ras_ptr <= ras_ptr;
         end else if (ras_push) begin
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_cnt != (PW+1)'(RAS_DEPTH))
               ras_cnt <= ras_cnt + 1'b1;
         end else if (ras_hit) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
         end
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = inst_jalr_i & (RAS_DEPTH > 1);
   assign taken      = static_taken;
   assign target     = branch_target;
`endif

   assign next_pc = taken ? target : pc_plus4;

   // Redirect beats stall; a stall freezes the PC and the whole IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         inst_q  <= NOP;
         addr_q  <= 32'd0;
         taken_q <= 1'b0;
         paddr_q <= 32'd0;
      end else if (jump_flag_i) begin
         pc      <= jump_addr_i;
         inst_q  <= NOP;
         addr_q  <= 32'd0;
         taken_q <= 1'b0;
         paddr_q <= 32'd0;
      end else if (!hold_flag_i) begin
         pc      <= next_pc;
         inst_q  <= inst_i;
         addr_q  <= pc;
         taken_q <= taken;
         paddr_q <= next_pc;
      end
   end

endmodule

// File: tb/tb_if_predict.sv
// Directed scoreboard bench for if_predict; expected state after each edge is queued
// by the driver and checked by an independent monitor. Honours IF_PREDICT_RAS_EN.
module tb_if_predict;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i;
   logic        inst_jal_i;
   logic        inst_jalr_i;
   logic        inst_bxx_i;
   logic [31:0] jump_and_branch_imm_i;
   logic        hold_flag_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        pred_taken_o;
   logic [31:0] pred_addr_o;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] addr;
      logic        taken;
      logic [31:0] paddr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] I_A  = 32'h0010_0093;
   localparam logic [31:0] I_B  = 32'h0020_0113;
   localparam logic [31:0] I_C  = 32'h0030_0193;
   localparam logic [31:0] I_BB = 32'hFE00_0863;
   localparam logic [31:0] I_BF = 32'h0000_0863;
   localparam logic [31:0] I_J0 = 32'h0100_006F;
   localparam logic [31:0] I_JN = 32'hFF9F_F06F;
   localparam logic [31:0] I_J1 = 32'h0400_00EF;
   localparam logic [31:0] I_JR = 32'h0000_8067;

   always #5 clk = ~clk;

   if_predict dut (
      .clk                   (clk),
      .rst                   (rst),
      .inst_i                (inst_i),
      .inst_jal_i            (inst_jal_i),
      .inst_jalr_i           (inst_jalr_i),
      .inst_bxx_i            (inst_bxx_i),
      .jump_and_branch_imm_i (jump_and_branch_imm_i),
      .hold_flag_i           (hold_flag_i),
      .jump_flag_i           (jump_flag_i),
      .jump_addr_i           (jump_addr_i),
      .pc_o                  (pc_o),
      .inst_o                (inst_o),
      .inst_addr_o           (inst_addr_o),
      .pred_taken_o          (pred_taken_o),
      .pred_addr_o           (pred_addr_o)
   );

   // Drive one cycle of inputs at the falling edge and queue the post-edge state.
   task automatic step(input string name, input logic r, input logic [31:0] inst,
                       input logic jal, input logic jalr, input logic bxx,
                       input logic [31:0] imm, input logic hold, input logic jmp,
                       input logic [31:0] jaddr, input logic [31:0] e_pc,
                       input logic [31:0] e_inst, input logic [31:0] e_addr,
                       input logic e_taken, input logic [31:0] e_paddr);
      exp_t e;
      @(negedge clk);
      rst = r; inst_i = inst; inst_jal_i = jal; inst_jalr_i = jalr; inst_bxx_i = bxx;
      jump_and_branch_imm_i = imm; hold_flag_i = hold; jump_flag_i = jmp; jump_addr_i = jaddr;
      e.name = name; e.pc = e_pc; e.inst = e_inst; e.addr = e_addr;
      e.taken = e_taken; e.paddr = e_paddr;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (pc_o !== e.pc || inst_o !== e.inst || inst_addr_o !== e.addr ||
             pred_taken_o !== e.taken || pred_addr_o !== e.paddr) begin
            n_fail++;
            $display("FAIL %s: got pc=%h inst=%h addr=%h taken=%b paddr=%h, want pc=%h inst=%h addr=%h taken=%b paddr=%h",
                     e.name, pc_o, inst_o, inst_addr_o, pred_taken_o, pred_addr_o,
                     e.pc, e.inst, e.addr, e.taken, e.paddr);
         end
      end
   end

   initial begin
      logic [31:0] r_pc;
      logic        r_tk;
      rst = 1'b1; inst_i = NOP; inst_jal_i = 1'b0; inst_jalr_i = 1'b0; inst_bxx_i = 1'b0;
      jump_and_branch_imm_i = 32'd0; hold_flag_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'd0;

      //    name         rst inst  jal jr bxx imm            hold jmp jaddr          pc             inst  addr           tk paddr
      step("reset0",     1, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h0,         NOP,  32'h0,         0, 32'h0);
      step("reset1",     1, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h0,         NOP,  32'h0,         0, 32'h0);
      step("seq0",       0, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h4,         I_A,  32'h0,         0, 32'h4);
      step("seq4",       0, I_B,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h8,         I_B,  32'h4,         0, 32'h8);
      step("redir100",   0, I_C,  0, 0, 0, 32'd0,          0, 1, 32'h100,        32'h100,       NOP,  32'h0,         0, 32'h0);
      step("bwd_taken",  0, I_BB, 0, 0, 1, 32'hFFFF_FFF0,  0, 0, 32'd0,          32'hF0,        I_BB, 32'h100,       1, 32'hF0);
      step("after_bwd",  0, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'hF4,        I_A,  32'hF0,        0, 32'hF4);
      step("redir100b",  0, I_B,  0, 0, 0, 32'd0,          0, 1, 32'h100,        32'h100,       NOP,  32'h0,         0, 32'h0);
      step("fwd_ntaken", 0, I_BF, 0, 0, 1, 32'h10,         0, 0, 32'd0,          32'h104,       I_BF, 32'h100,       0, 32'h104);
      step("redir100c",  0, I_B,  0, 0, 0, 32'd0,          0, 1, 32'h100,        32'h100,       NOP,  32'h0,         0, 32'h0);
      step("jal_fwd",    0, I_J0, 1, 0, 0, 32'h10,         0, 0, 32'd0,          32'h110,       I_J0, 32'h100,       1, 32'h110);
      step("hold_jump",  0, I_A,  1, 0, 0, 32'h10,         1, 1, 32'h200,        32'h200,       NOP,  32'h0,         0, 32'h0);
      step("seq200",     0, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h204,       I_A,  32'h200,       0, 32'h204);
      step("hold1",      0, I_B,  1, 0, 0, 32'h40,         1, 0, 32'd0,          32'h204,       I_A,  32'h200,       0, 32'h204);
      step("hold2",      0, I_B,  0, 0, 0, 32'd0,          1, 0, 32'd0,          32'h204,       I_A,  32'h200,       0, 32'h204);
      step("hold3",      0, I_B,  0, 0, 0, 32'd0,          1, 0, 32'd0,          32'h204,       I_A,  32'h200,       0, 32'h204);
      step("release",    0, I_B,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h208,       I_B,  32'h204,       0, 32'h208);
      step("redir_top",  0, I_C,  0, 0, 0, 32'd0,          0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, NOP,  32'h0,         0, 32'h0);
      step("wrap_pc4",   0, I_A,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h0,         I_A,  32'hFFFF_FFFC, 0, 32'h0);
      step("jal_wrapdn", 0, I_JN, 1, 0, 0, 32'hFFFF_FFF8,  0, 0, 32'd0,          32'hFFFF_FFF8, I_JN, 32'h0,         1, 32'hFFFF_FFF8);
      step("jal_wrapup", 0, I_J0, 1, 0, 0, 32'h10,         0, 0, 32'd0,          32'h8,         I_J0, 32'hFFFF_FFF8, 1, 32'h8);
      step("redir40",    0, I_A,  0, 0, 0, 32'd0,          0, 1, 32'h40,         32'h40,        NOP,  32'h0,         0, 32'h0);
      step("jal_x1",     0, I_J1, 1, 0, 0, 32'h40,         0, 0, 32'd0,          32'h80,        I_J1, 32'h40,        1, 32'h80);
`ifdef IF_PREDICT_RAS_EN
      r_pc = 32'h44; r_tk = 1'b1;
`else
      r_pc = 32'h84; r_tk = 1'b0;
`endif
      step("jalr_ret",   0, I_JR, 0, 1, 0, 32'd0,          0, 0, 32'd0,          r_pc,          I_JR, 32'h80,        r_tk, r_pc);
      step("jalr_empty", 0, I_JR, 0, 1, 0, 32'd0,          0, 0, 32'd0,          r_pc + 32'h4,  I_JR, r_pc,          0, r_pc + 32'h4);
      step("rst_mid",    1, I_A,  1, 0, 0, 32'h40,         1, 1, 32'h300,        32'h0,         NOP,  32'h0,         0, 32'h0);
      step("post_rst",   0, I_B,  0, 0, 0, 32'd0,          0, 0, 32'd0,          32'h4,         I_B,  32'h0,         0, 32'h4);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
